image_auto_gain_ctrl: RTL
=========================

Name: image_auto_gain_ctrl

Overview:
- Upstream controller for the linear contrast stage. It measures mean luma over each frame and computes the 9-bit gain word (0..511 maps to 0..~2, 256 = 1.0) that drives the contrast stage's adjust_val input.
- Sits in parallel with the pixel path and taps the same vs/valid/data stream. The new gain takes effect only on a frame boundary.

Parameters:
- SUM_W, 32, luma accumulator width (saturating).
- CNT_W, 24, pixel counter width (saturating).
- DEFAULT_GAIN, 256, gain after reset and before the first computed value.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- agc_en  in  1  1: automatic gain; 0: manual_gain passed through.
- manual_gain  in  9  gain used when agc_en=0.
- target_luma  in  8  desired frame mean luma.
- vs_in  in  1  vertical sync, active high.
- valid_i  in  1  pixel qualifier.
- img_data_i  in  24  {R,G,B}, 8 bits each.
- adjust_val  out  9  gain to the contrast stage.
- gain_update  out  1  one-cycle pulse when adjust_val changes in auto mode.
- busy  out  1  divider running or result pending commit.

Behaviour:
- Reset values: adjust_val=DEFAULT_GAIN, gain_update=0, busy=0. Accumulators, counter and result registers are cleared; FSM goes to IDLE. Reset asserted mid-division aborts the division with no commit.
- Luma stage, registered, 1 cycle:
  - Y = (77*R + 150*G + 29*B) >> 8, 8-bit.
  - y_valid = valid_i delayed 1; vs_d = vs_in delayed 1.
- Accumulate, on y_valid:
  - sum += Y, saturating at 2^SUM_W-1.
  - cnt += 1, saturating at 2^CNT_W-1.
- Frame end is the rising edge of vs_d (vs_d=1, previous value 0). On that cycle:
  - snap_sum = sum + (y_valid ? Y : 0); snap_cnt likewise. The last pixel belongs to the ending frame.
  - sum and cnt clear to 0.
- FSM states IDLE, DIV, PEND:
  - IDLE -> DIV on frame end with snap_cnt != 0.
  - Frame end with snap_cnt == 0: stay in IDLE, gain unchanged.
  - Entering DIV loads numerator N = target_luma * snap_cnt * 256 (CNT_W+16 bits) and denominator D = snap_sum.
  - DIV: restoring divider, one quotient bit per cycle, CNT_W+16 cycles. Then -> PEND with result = min(N/D, 511), quotient truncated.
  - D == 0 (all-black frame): skip the divide, result = 511, go directly to PEND.
  - PEND -> IDLE on the first falling edge of vs_in (raw input, not delayed). That same cycle commits adjust_val <= result and pulses gain_update. If vs_in is already low when PEND is entered, commit on the next cycle.
  - A frame end while in DIV or PEND discards the in-flight result and restarts DIV with the new snapshot.
- busy = (state != IDLE).
- Manual mode (agc_en=0):
  - adjust_val = manual_gain, registered; 1-cycle latency; changes at any time.
  - gain_update stays 0.
  - Statistics and FSM keep running. A pending result is dropped at commit time.
- On agc_en 0->1: adjust_val holds manual_gain until the next auto commit.

Optional Feature:
- Macro AGC_SMOOTH_EN.
- When defined, the commit writes adjust_val <= (3*adjust_val + result + 2) >> 2, a rounded IIR that suppresses frame-to-frame flicker. gain_update pulses only if the value actually changes.
- When undefined, the commit writes result directly.

Test Plan:
- Reset, then a 100-pixel frame with R=G=B=128, target 128, then vs falling edge -> adjust_val=256, one gain_update pulse, busy low afterwards.
- 100 pixels of gray 64, target 128 -> quotient 512, clamped, adjust_val=511.
- 100 pixels of gray 255, target 128 -> 3276800/25500 = 128, adjust_val=128. With AGC_SMOOTH_EN from a 256 start -> 224.
- All-black frame -> 511. Frame with zero valid pixels -> adjust_val unchanged, no gain_update, busy never asserts.
- Second vs rising edge during DIV -> first result never appears; adjust_val reflects the second frame only. Reset_n pulsed during DIV -> adjust_val=256 immediately, no commit.
- agc_en=0, manual_gain=300 -> adjust_val=300 after 1 cycle, no gain_update. Stream an auto frame -> adjust_val stays 300.

Source files
------------

// File: rtl/image_auto_gain_ctrl.sv
// Frame-mean luma auto gain controller: measures mean Y per frame and commits a 9-bit gain at the vs falling edge.
// Optional build macro AGC_SMOOTH_EN blends each new result into the current gain with a rounded 3:1 IIR.
module image_auto_gain_ctrl #(
    parameter int SUM_W        = 32,
    parameter int CNT_W        = 24,
    parameter int DEFAULT_GAIN = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        agc_en,
    input  logic [8:0]  manual_gain,
    input  logic [7:0]  target_luma,
    input  logic        vs_in,
    input  logic        valid_i,
    input  logic [23:0] img_data_i,
    output logic [8:0]  adjust_val,
    output logic        gain_update,
    output logic        busy
);

    localparam int NW   = CNT_W + 16;
    localparam int PW   = CNT_W + 8;
    localparam int BC_W = $clog2(NW);

    // busy is bit 0 of the encoding so it comes straight from a flop
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_PEND = 2'b11
    } state_t;

    function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] a, input logic [7:0] b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + {{(SUM_W - 7){1'b0}}, b};
        if (t[SUM_W]) begin
            return {SUM_W{1'b1}};
        end else begin
            return t[SUM_W-1:0];
        end
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] a);
        if (&a) begin
            return a;
        end else begin
            return a + CNT_W'(1);
        end
    endfunction

    function automatic logic [8:0] clamp_gain(input logic [NW-1:0] q);
        if (|q[NW-1:9]) begin
            return 9'd511;
        end else begin
            return q[8:0];
        end
    endfunction

`ifdef AGC_SMOOTH_EN
    function automatic logic [8:0] iir_gain(input logic [8:0] prev, input logic [8:0] res);
        logic [10:0] acc;
        acc = 11'd3 * {2'd0, prev} + {2'd0, res} + 11'd2;
        return 9'(acc >> 2);
    endfunction
`endif

    logic [15:0]      luma_s;
    logic [7:0]       y_r;
    logic             y_valid_r;
    logic             vs_d_r;
    logic             vs_dd_r;
    logic             frame_end_s;
    logic [SUM_W-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic [SUM_W-1:0] snap_sum_s;
    logic [CNT_W-1:0] snap_cnt_s;
    logic [PW-1:0]    prod_s;
    logic [NW-1:0]    numer_s;

    state_t           state_r;
    logic [NW-1:0]    quo_r;
    logic [SUM_W-1:0] rem_r;
    logic [SUM_W-1:0] den_r;
    logic [BC_W-1:0]  bit_cnt_r;
    logic [8:0]       result_r;
    logic [SUM_W:0]   trial_s;
    logic             ge_s;
    logic [SUM_W-1:0] diff_s;
    logic [SUM_W-1:0] rem_next_s;
    logic [NW-1:0]    quo_next_s;
    logic [8:0]       commit_s;
    logic             upd_s;

    assign luma_s = 16'd77  * {8'd0, img_data_i[23:16]}
                  + 16'd150 * {8'd0, img_data_i[15:8]}
                  + 16'd29  * {8'd0, img_data_i[7:0]};

    // Luma pipeline stage and sync/qualifier delays
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_r       <= 8'd0;
            y_valid_r <= 1'b0;
            vs_d_r    <= 1'b0;
            vs_dd_r   <= 1'b0;
        end else begin
            y_r       <= 8'(luma_s >> 8);
            y_valid_r <= valid_i;
            vs_d_r    <= vs_in;
            vs_dd_r   <= vs_d_r;
        end
    end

    assign frame_end_s = vs_d_r & ~vs_dd_r;
    assign snap_sum_s  = y_valid_r ? sum_add(sum_r, y_r) : sum_r;
    assign snap_cnt_s  = y_valid_r ? cnt_inc(cnt_r) : cnt_r;
    assign prod_s      = PW'(target_luma) * PW'(snap_cnt_s);
    assign numer_s     = {prod_s, 8'd0};

    // Frame statistics; the pixel coincident with frame end goes into the snapshot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= {SUM_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (frame_end_s) begin
            sum_r <= {SUM_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (y_valid_r) begin
            sum_r <= sum_add(sum_r, y_r);
            cnt_r <= cnt_inc(cnt_r);
        end
    end

    // One restoring-division step; remainder stays below den_r so SUM_W bits suffice
    always_comb begin
        trial_s    = {rem_r, quo_r[NW-1]};
        ge_s       = (trial_s >= {1'b0, den_r});
        diff_s     = trial_s[SUM_W-1:0] - den_r;
        rem_next_s = ge_s ? diff_s : trial_s[SUM_W-1:0];
        quo_next_s = {quo_r[NW-2:0], ge_s};
    end

`ifdef AGC_SMOOTH_EN
    assign commit_s = iir_gain(adjust_val, result_r);
    assign upd_s    = (commit_s != adjust_val);
`else
    assign commit_s = result_r;
    assign upd_s    = 1'b1;
`endif

    // Gain FSM: divide, wait for vs low, then commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            quo_r       <= {NW{1'b0}};
            rem_r       <= {SUM_W{1'b0}};
            den_r       <= {SUM_W{1'b0}};
            bit_cnt_r   <= {BC_W{1'b0}};
            result_r    <= 9'd0;
            adjust_val  <= 9'(DEFAULT_GAIN);
            gain_update <= 1'b0;
        end else begin
            gain_update <= 1'b0;
            if (!agc_en) begin
                adjust_val <= manual_gain;
            end
            if (frame_end_s) begin
                // a new frame always supersedes any result still in flight
                if (|snap_cnt_s) begin
                    quo_r     <= numer_s;
                    rem_r     <= {SUM_W{1'b0}};
                    den_r     <= snap_sum_s;
                    bit_cnt_r <= BC_W'(NW - 1);
                    if (~|snap_sum_s) begin
                        result_r <= 9'd511;
                        state_r  <= ST_PEND;
                    end else begin
                        state_r  <= ST_DIV;
                    end
                end else begin
                    state_r <= ST_IDLE;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_DIV: begin
                        quo_r <= quo_next_s;
                        rem_r <= rem_next_s;
                        if (bit_cnt_r == BC_W'(0)) begin
                            result_r <= clamp_gain(quo_next_s);
                            state_r  <= ST_PEND;
                        end else begin
                            bit_cnt_r <= bit_cnt_r - BC_W'(1);
                        end
                    end
                    ST_PEND: begin
                        if (!vs_in) begin
                            state_r <= ST_IDLE;
                            if (agc_en) begin
                                adjust_val  <= commit_s;
                                gain_update <= upd_s;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = state_r[0];

endmodule
